// File: rtl/i2c_addr_slave_frontend.sv
// rtl/i2c_addr_slave_frontend.sv - upstream I2C target front-end of the address translator
//
// Purpose: answers two virtual 7-bit addresses on the upstream bus. On a match it
// ACKs, presents the translated real address and pulses a trigger to the
// downstream master. It then ACKs and forwards each received write data byte.
//
// Ports:
//   clk, rst_n     system clock (>= 8x SCL rate), asynchronous active-low reset
//   scl_in, sda_in upstream bus lines (asynchronous to clk)
//   master_busy    downstream master mid-transaction; the address is NACKed
//   sda_out        SDA drive value (0 whenever sda_en=1)
//   sda_en         open-drain SDA pull-low enable
//   real_addr      translated address, valid from trigger_out until the next match
//   trigger_out    1-clk pulse: start a downstream write to real_addr
//   rx_data        last received data byte
//   rx_valid       1-clk pulse: rx_data updated
//   busy           high from START until STOP
module i2c_addr_slave_frontend #(
  parameter logic [6:0] VIRT_ADDR0 = 7'h48,
  parameter logic [6:0] REAL_ADDR0 = 7'h20,
  parameter logic [6:0] VIRT_ADDR1 = 7'h49,
  parameter logic [6:0] REAL_ADDR1 = 7'h21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  input  logic       master_busy,
  output logic       sda_out,
  output logic       sda_en,
  output logic [6:0] real_addr,
  output logic       trigger_out,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_IGNORE
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [7:0]  shift, shift_nxt;
  logic        match, match_nxt;
  logic        sel, sel_nxt;
  logic        sda_en_nxt, trigger_nxt, rx_valid_nxt;
  logic [6:0]  real_addr_nxt;
  logic [7:0]  rx_data_nxt;

  // Synchronizers reset to the idle-bus level so that reset release does not
  // fabricate a START or STOP.
  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {scl_s1, scl_s2, scl_d} <= 3'b111;
      {sda_s1, sda_s2, sda_d} <= 3'b111;
    end else begin
      scl_s1 <= scl_in;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  logic scl_rise, scl_fall, start_cond, stop_cond;
  assign scl_rise   = scl_s2 & ~scl_d;
  assign scl_fall   = ~scl_s2 & scl_d;
  assign start_cond = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_cond  = scl_s2 & scl_d & ~sda_d & sda_s2;

  // Open-drain: only ever pull low.
  assign sda_out = ~sda_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      shift       <= 8'd0;
      match       <= 1'b0;
      sel         <= 1'b0;
      sda_en      <= 1'b0;
      real_addr   <= 7'd0;
      trigger_out <= 1'b0;
      rx_data     <= 8'd0;
      rx_valid    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      shift       <= shift_nxt;
      match       <= match_nxt;
      sel         <= sel_nxt;
      sda_en      <= sda_en_nxt;
      real_addr   <= real_addr_nxt;
      trigger_out <= trigger_nxt;
      rx_data     <= rx_data_nxt;
      rx_valid    <= rx_valid_nxt;
      busy        <= (state_nxt != S_IDLE);
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    shift_nxt     = shift;
    match_nxt     = match;
    sel_nxt       = sel;
    sda_en_nxt    = sda_en;
    real_addr_nxt = real_addr;
    trigger_nxt   = 1'b0;
    rx_data_nxt   = rx_data;
    rx_valid_nxt  = 1'b0;

    // Bus conditions override any SCL edge seen in the same clk.
    if (stop_cond) begin
      state_nxt  = S_IDLE;
      sda_en_nxt = 1'b0;
    end else if (start_cond) begin
      state_nxt  = S_ADDR;
      cnt_nxt    = 4'd0;
      sda_en_nxt = 1'b0;
    end else begin
      case (state)
        S_ADDR: begin
          if (scl_rise && cnt < 4'd8) begin
            shift_nxt = {shift[6:0], sda_s2};
            cnt_nxt   = cnt + 4'd1;
            if (cnt == 4'd7) begin
              // shift[6:0] holds the 7 address bits; sda_s2 is R/W.
              // master_busy is sampled only here.
              match_nxt = ((shift[6:0] == VIRT_ADDR0) || (shift[6:0] == VIRT_ADDR1))
                          && !sda_s2 && !master_busy;
              sel_nxt   = (shift[6:0] != VIRT_ADDR0);
            end
          end else if (scl_fall && cnt == 4'd8) begin
            if (match) begin
              state_nxt     = S_ADDR_ACK;
              sda_en_nxt    = 1'b1;
              real_addr_nxt = sel ? REAL_ADDR1 : REAL_ADDR0;
              trigger_nxt   = 1'b1;
            end else begin
              state_nxt = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK, S_DATA_ACK: begin
          if (scl_fall) begin
            state_nxt  = S_DATA;
            sda_en_nxt = 1'b0;
            cnt_nxt    = 4'd0;
          end
        end
        S_DATA: begin
          if (scl_rise && cnt < 4'd8) begin
            shift_nxt = {shift[6:0], sda_s2};
            cnt_nxt   = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            state_nxt    = S_DATA_ACK;
            rx_data_nxt  = shift;
            rx_valid_nxt = 1'b1;
            sda_en_nxt   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_addr_slave_frontend.sv
// tb/tb_i2c_addr_slave_frontend.sv - directed bench for i2c_addr_slave_frontend
module tb_i2c_addr_slave_frontend;

  localparam time Q = 40ns;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       master_busy = 1'b0;
  logic       sda_out, sda_en, trigger_out, rx_valid, busy;
  logic [6:0] real_addr;
  logic [7:0] rx_data;
  logic       sda_bus;

  assign sda_bus = sda_m & ~(sda_en & ~sda_out);

  i2c_addr_slave_frontend dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl_m), .sda_in(sda_bus),
    .master_busy(master_busy), .sda_out(sda_out), .sda_en(sda_en),
    .real_addr(real_addr), .trigger_out(trigger_out), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy)
  );

  always #5ns clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Monitor, sampled on the falling clk edge.
  int         trig_cnt = 0;
  int         rx_cnt = 0;
  int         drive_cnt = 0;
  int         viol = 0;
  logic [6:0] trig_addr = 7'd0;
  logic [7:0] rx_log [0:63];
  logic       prev_trig = 1'b0, prev_rxv = 1'b0;

  always @(negedge clk) begin
    if (trigger_out) begin
      trig_cnt++;
      trig_addr = real_addr;
    end
    if (rx_valid) begin
      rx_log[rx_cnt[5:0]] = rx_data;
      rx_cnt++;
    end
    if (sda_en) drive_cnt++;
    if ((trigger_out && rx_valid) || (trigger_out && prev_trig) || (rx_valid && prev_rxv)) viol++;
    prev_trig = trigger_out;
    prev_rxv  = rx_valid;
  end

  task automatic i2c_start();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; #Q;
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    ack = ~sda_bus;
    #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic ack;
  int   t0, r0, d0;
  logic [7:0] bytes3 [3];

  initial begin
    bytes3[0] = 8'h01; bytes3[1] = 8'h02; bytes3[2] = 8'h03;

    // Reset state
    idle(3);
    check("rst_sda_out", sda_out, 1);
    check("rst_sda_en", sda_en, 0);
    check("rst_real_addr", real_addr, 0);
    check("rst_trigger", trigger_out, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    idle(5);

    // Write 0x48, data 0xAA
    t0 = trig_cnt; r0 = rx_cnt;
    i2c_start();
    idle(4);
    check("t1_busy_after_start", busy, 1);
    send_byte(8'h90, ack);
    check("t1_addr_ack", ack, 1);
    check("t1_trig_count", trig_cnt - t0, 1);
    check("t1_real_addr", trig_addr, 7'h20);
    send_byte(8'hAA, ack);
    check("t1_data_ack", ack, 1);
    i2c_stop();
    idle(6);
    check("t1_rx_count", rx_cnt - r0, 1);
    check("t1_rx_byte", rx_log[r0[5:0]], 8'hAA);
    check("t1_busy_after_stop", busy, 0);
    check("t1_sda_released", sda_en, 0);

    // Write 0x49, three bytes
    t0 = trig_cnt; r0 = rx_cnt;
    i2c_start();
    send_byte(8'h92, ack);
    check("t2_addr_ack", ack, 1);
    for (int i = 0; i < 3; i++) begin
      send_byte(bytes3[i], ack);
      check($sformatf("t2_data_ack%0d", i), ack, 1);
    end
    i2c_stop();
    idle(6);
    check("t2_trig_count", trig_cnt - t0, 1);
    check("t2_real_addr", trig_addr, 7'h21);
    check("t2_rx_count", rx_cnt - r0, 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("t2_rx_byte%0d", i), rx_log[(r0 + i) % 64], bytes3[i]);

    // Write 0x50: not ours
    t0 = trig_cnt; r0 = rx_cnt; d0 = drive_cnt;
    i2c_start();
    send_byte(8'hA0, ack);
    check("t3_nack", ack, 0);
    send_byte(8'h5A, ack);
    i2c_stop();
    idle(6);
    check("t3_never_driven", drive_cnt - d0, 0);
    check("t3_no_trig", trig_cnt - t0, 0);
    check("t3_no_rx", rx_cnt - r0, 0);
    check("t3_idle", busy, 0);

    // Read to 0x48, then write to 0x48 with master_busy
    t0 = trig_cnt; d0 = drive_cnt;
    i2c_start();
    send_byte(8'h91, ack);
    check("t4_read_nack", ack, 0);
    i2c_stop();
    idle(4);
    master_busy = 1'b1;
    i2c_start();
    send_byte(8'h90, ack);
    check("t4_busy_nack", ack, 0);
    master_busy = 1'b0;
    i2c_stop();
    idle(6);
    check("t4_no_trig", trig_cnt - t0, 0);
    check("t4_never_driven", drive_cnt - d0, 0);

    // Repeated START after 4 data bits
    t0 = trig_cnt; r0 = rx_cnt;
    i2c_start();
    send_byte(8'h90, ack);
    check("t5_addr0_ack", ack, 1);
    check("t5_real_addr0", trig_addr, 7'h20);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_start();
    send_byte(8'h92, ack);
    check("t5_addr1_ack", ack, 1);
    check("t5_trig_count", trig_cnt - t0, 2);
    check("t5_real_addr1", trig_addr, 7'h21);
    send_byte(8'h55, ack);
    check("t5_data_ack", ack, 1);
    i2c_stop();
    idle(6);
    check("t5_rx_count", rx_cnt - r0, 1);
    check("t5_rx_byte", rx_log[r0[5:0]], 8'h55);
    check("t5_rx_data", rx_data, 8'h55);

    // Reset while driving the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(logic'(8'h90 >> i));
    sda_m = 1'b1;
    idle(1);
    check("t6_acking", sda_en, 1);
    #2ns rst_n = 1'b0;
    #1ns;
    check("t6_async_release", sda_en, 0);
    check("t6_sda_out", sda_out, 1);
    check("t6_real_addr", real_addr, 0);
    check("t6_rx_data", rx_data, 0);
    check("t6_busy", busy, 0);
    check("t6_trigger", trigger_out, 0);
    check("t6_rx_valid", rx_valid, 0);
    idle(3);
    rst_n = 1'b1;
    scl_m = 1'b1;
    idle(8);
    t0 = trig_cnt; r0 = rx_cnt;
    i2c_start();
    send_byte(8'h90, ack);
    check("t6_post_addr_ack", ack, 1);
    check("t6_post_real_addr", trig_addr, 7'h20);
    send_byte(8'h3C, ack);
    check("t6_post_data_ack", ack, 1);
    i2c_stop();
    idle(6);
    check("t6_post_trig", trig_cnt - t0, 1);
    check("t6_post_rx_count", rx_cnt - r0, 1);
    check("t6_post_rx_byte", rx_log[r0[5:0]], 8'h3C);
    check("t6_post_idle", busy, 0);

    check("pulse_rules", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_addr_slave_frontend.md
Name: i2c_addr_slave_frontend

Overview:
Upstream I2C target front-end of the address translator. It receives host transactions on the upstream bus and matches the 7-bit virtual address against two translation entries. On a match it ACKs, presents the translated real address and pulses a trigger to the downstream I2C master stage. It then accepts write data bytes and forwards each one to the master side.

Parameters:
VIRT_ADDR0, 7'h48, first virtual address answered on the upstream bus
REAL_ADDR0, 7'h20, real address substituted for VIRT_ADDR0
VIRT_ADDR1, 7'h49, second virtual address
REAL_ADDR1, 7'h21, real address substituted for VIRT_ADDR1

Ports:
clk  in  1  system clock; at least 8x the SCL rate
rst_n  in  1  reset
scl_in  in  1  upstream SCL, asynchronous
sda_in  in  1  upstream SDA, asynchronous
master_busy  in  1  downstream master is mid-transaction; address must be NACKed
sda_out  out  1  SDA drive value; always 0 when sda_en=1
sda_en  out  1  SDA output enable; open-drain pull-low
real_addr  out  7  translated address; valid from trigger_out until next START
trigger_out  out  1  one-clk pulse; start downstream write to real_addr
rx_data  out  8  last received data byte
rx_valid  out  1  one-clk pulse; rx_data updated
busy  out  1  high from START until STOP or return to IDLE

Behaviour:
- Reset is asynchronous and active-low on rst_n; clock is clk.
- Reset values: sda_out=1, sda_en=0, real_addr=0, trigger_out=0, rx_data=0, rx_valid=0, busy=0, state=S_IDLE, bit counter=0.
- scl_in and sda_in each pass through a 2-FF synchronizer. Edge and condition detection uses the synchronized values plus one delayed copy.
- START: synchronized SDA falls while synchronized SCL is high.
- STOP: synchronized SDA rises while synchronized SCL is high.
- Data bits are sampled on synchronized SCL rising edges, MSB first.
- States:
  - S_IDLE: wait for START; on START go to S_ADDR and clear the bit counter.
  - S_ADDR: shift 8 bits (7 address bits, then R/W). On the 8th rising edge, decide as follows:
    - match = (addr==VIRT_ADDR0 or addr==VIRT_ADDR1) and R/W==0 and master_busy==0.
    - If both entries are equal, entry 0 wins.
  - After the 8th bit, at the next SCL falling edge:
    - match: go to S_ADDR_ACK, set sda_en=1, load real_addr, and pulse trigger_out in the same clk.
    - no match (including reads, or master_busy=1): go to S_IGNORE with sda_en=0 (NACK).
  - S_ADDR_ACK: hold sda_en=1 until the next SCL falling edge. Then release SDA (sda_en=0), go to S_DATA and clear the bit counter.
  - S_DATA: shift 8 bits. At the SCL falling edge after the 8th bit:
    - load rx_data;
    - pulse rx_valid for 1 clk;
    - assert sda_en (ACK);
    - go to S_DATA_ACK.
  - S_DATA_ACK: at the next SCL falling edge, release SDA and go to S_DATA. Multi-byte writes are supported.
  - S_IGNORE: SDA released; wait for START or STOP.
- Bus conditions in any state:
  - STOP: go to S_IDLE, sda_en=0, busy=0. A partial byte is discarded with no rx_valid.
  - START (repeated START): go to S_ADDR and clear the counter. real_addr holds until a new match.
- ACK is only ever driven while SCL is low at the drive instant. sda_en never changes while synchronized SCL is high.
- Simultaneous events:
  - START or STOP seen in the same clk as an SCL edge takes priority over the edge.
  - master_busy is sampled only at the address decision. A later change has no effect on the current transaction.
- trigger_out and rx_valid are never asserted together and never held longer than 1 clk.
- Reset mid-transaction releases SDA immediately (asynchronous) and discards all in-progress state.

Test Plan:
- Write to 0x48, data 0xAA then STOP -> address ACK; trigger_out 1-clk pulse with real_addr=0x20; one rx_valid with rx_data=0xAA; data ACK; busy low after STOP.
- Write to 0x49, 3 bytes 0x01,0x02,0x03 -> real_addr=0x21, a single trigger, three rx_valid pulses in order, each byte ACKed.
- Write to 0x50 -> SDA never driven (NACK), no trigger, no rx_valid; block idle after STOP.
- Read to 0x48 (R/W=1), then write to 0x48 with master_busy=1 -> both NACKed, no trigger.
- Write to 0x48, then repeated START after 4 data bits, then write to 0x49 with byte 0x55 -> partial byte discarded; second trigger with real_addr=0x21; rx_data=0x55.
- rst_n low while the block drives the address ACK -> sda_en=0 within the same clk; all outputs at reset values; the next full transaction completes normally.
